// File: rtl/cart_pkg.sv
// cart_pkg: shared types and constants for the cartridge memory arbiter.
package cart_pkg;

    localparam int CART_ADDR_W = 21;

    // Requester identifiers (one bit: the arbiter only ever serves two ports)
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_PPU = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } cart_state_e;

endpackage

// File: rtl/cart_arbiter_if.sv
// cart_arbiter_if: CPU port, PPU port and cartridge memory bus bundled together.
// master = arbiter side, slave = requesters plus memory.
interface cart_arbiter_if
    import cart_pkg::*;
#(
    parameter int ADDR_W = CART_ADDR_W
);
    logic              cpu_req;
    logic              cpu_ram;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;

    logic              ppu_req;
    logic              ppu_we;
    logic [ADDR_W-1:0] ppu_addr;
    logic [7:0]        ppu_wdata;
    logic              ppu_ack;
    logic [7:0]        ppu_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_prg_sel;
    logic              mem_chr_sel;
    logic              mem_ram_sel;
    logic              mem_rden;
    logic              mem_wren;
    logic [7:0]        mem_write_data;
    logic [7:0]        mem_read_data;

    modport master (
        input  cpu_req, cpu_ram, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  ppu_req, ppu_we, ppu_addr, ppu_wdata,
        output ppu_ack, ppu_rdata,
        output mem_address, mem_prg_sel, mem_chr_sel, mem_ram_sel,
        output mem_rden, mem_wren, mem_write_data,
        input  mem_read_data
    );

    modport slave (
        output cpu_req, cpu_ram, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output ppu_req, ppu_we, ppu_addr, ppu_wdata,
        input  ppu_ack, ppu_rdata,
        input  mem_address, mem_prg_sel, mem_chr_sel, mem_ram_sel,
        input  mem_rden, mem_wren, mem_write_data,
        output mem_read_data
    );

endinterface

// File: rtl/cart_arb_pick.sv
// cart_arb_pick: combinational winner select between CPU and PPU.
// CART_ARB_ROUND_ROBIN_EN defined: ties go to whoever was not granted last.
// Undefined: PPU always wins a tie.
module cart_arb_pick
    import cart_pkg::*;
(
    input  logic cpu_req,
    input  logic ppu_req,
`ifdef CART_ARB_ROUND_ROBIN_EN
    input  logic last_id,
`endif
    output logic grant_any,
    output logic grant_id
);

    // Winner select; a lone requester always wins
    always_comb begin
        grant_any = cpu_req | ppu_req;
`ifdef CART_ARB_ROUND_ROBIN_EN
        if (cpu_req && ppu_req)
            grant_id = (last_id == REQ_PPU) ? REQ_CPU : REQ_PPU;
        else
            grant_id = ppu_req ? REQ_PPU : REQ_CPU;
`else
        grant_id = ppu_req ? REQ_PPU : REQ_CPU;
`endif
    end

endmodule

// File: rtl/cart_arbiter.sv
// cart_arbiter: shares one cartridge memory port between CPU (PRG/SRAM) and
// PPU (CHR). IDLE -> ISSUE -> [WAIT] -> DONE, all memory outputs registered.
// Optional macro CART_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it the PPU has fixed priority.
module cart_arbiter
    import cart_pkg::*;
#(
    parameter int ADDR_W      = CART_ADDR_W,
    parameter int MEM_LATENCY = 2
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           cart_ready,
    cart_arbiter_if.master bus
);

    cart_state_e       state;
    logic              win_id;
    logic              win_we;
    logic [2:0]        lat_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic              prg_q, chr_q, ram_q, rden_q, wren_q;
    logic              cpu_ack_q, ppu_ack_q;
    logic [7:0]        cpu_rdata_q, ppu_rdata_q;

    logic              pick_any, pick_id, pick_we;
    logic [ADDR_W-1:0] pick_addr;
    logic [7:0]        pick_wdata;

`ifdef CART_ARB_ROUND_ROBIN_EN
    logic              last_id;
`endif

    cart_arb_pick u_pick (
        .cpu_req   (bus.cpu_req),
        .ppu_req   (bus.ppu_req),
`ifdef CART_ARB_ROUND_ROBIN_EN
        .last_id   (last_id),
`endif
        .grant_any (pick_any),
        .grant_id  (pick_id)
    );

    assign pick_we    = (pick_id == REQ_PPU) ? bus.ppu_we    : bus.cpu_we;
    assign pick_addr  = (pick_id == REQ_PPU) ? bus.ppu_addr  : bus.cpu_addr;
    assign pick_wdata = (pick_id == REQ_PPU) ? bus.ppu_wdata : bus.cpu_wdata;

    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.mem_prg_sel    = prg_q;
    assign bus.mem_chr_sel    = chr_q;
    assign bus.mem_ram_sel    = ram_q;
    assign bus.mem_rden       = rden_q;
    assign bus.mem_wren       = wren_q;
    assign bus.cpu_ack        = cpu_ack_q;
    assign bus.ppu_ack        = ppu_ack_q;
    assign bus.cpu_rdata      = cpu_rdata_q;
    assign bus.ppu_rdata      = ppu_rdata_q;

    // Transaction FSM; strobes and acks default low so each lasts one cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            win_id      <= REQ_CPU;
            win_we      <= 1'b0;
            lat_cnt     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            prg_q       <= 1'b0;
            chr_q       <= 1'b0;
            ram_q       <= 1'b0;
            rden_q      <= 1'b0;
            wren_q      <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ppu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ppu_rdata_q <= '0;
`ifdef CART_ARB_ROUND_ROBIN_EN
            last_id     <= REQ_CPU;
`endif
        end else begin
            prg_q     <= 1'b0;
            chr_q     <= 1'b0;
            ram_q     <= 1'b0;
            rden_q    <= 1'b0;
            wren_q    <= 1'b0;
            cpu_ack_q <= 1'b0;
            ppu_ack_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cart_ready && pick_any) begin
                        win_id  <= pick_id;
                        win_we  <= pick_we;
                        lat_cnt <= 3'(MEM_LATENCY - 1);
                        addr_q  <= pick_addr;
                        // write data bus only moves on writes
                        if (pick_we)
                            wdata_q <= pick_wdata;
                        rden_q  <= ~pick_we;
                        wren_q  <= pick_we;
                        prg_q   <= (pick_id == REQ_CPU) && !bus.cpu_ram;
                        ram_q   <= (pick_id == REQ_CPU) &&  bus.cpu_ram;
                        chr_q   <= (pick_id == REQ_PPU);
`ifdef CART_ARB_ROUND_ROBIN_EN
                        last_id <= pick_id;
`endif
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (win_we) begin
                        cpu_ack_q <= (win_id == REQ_CPU);
                        ppu_ack_q <= (win_id == REQ_PPU);
                        state     <= ST_DONE;
                    end else begin
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // counter reaching zero marks the cycle read data is valid
                    if (lat_cnt == 3'd0) begin
                        cpu_ack_q <= (win_id == REQ_CPU);
                        ppu_ack_q <= (win_id == REQ_PPU);
                        if (win_id == REQ_PPU)
                            ppu_rdata_q <= bus.mem_read_data;
                        else
                            cpu_rdata_q <= bus.mem_read_data;
                        state <= ST_DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cart_arbiter.sv
// tb_cart_arbiter: directed-vector bench for cart_arbiter (MEM_LATENCY = 2).
module tb_cart_arbiter;
    import cart_pkg::*;

    localparam int AW  = 21;
    localparam int LAT = 2;

    logic clock = 1'b0;
    logic reset_n;
    logic cart_ready;
    int   n_chk  = 0;
    int   n_pass = 0;

    cart_arbiter_if #(.ADDR_W(AW)) bus ();

    cart_arbiter #(.ADDR_W(AW), .MEM_LATENCY(LAT)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cart_ready (cart_ready),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    // Memory model: read data appears exactly LAT cycles after the strobe cycle
    logic [LAT:1] vld = '0;
    logic [AW-1:0] adr_p [1:LAT];

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        return (a == 21'h00123) ? 8'hA5 : (a[7:0] ^ 8'h5A);
    endfunction

    always @(posedge clock) begin
        vld[1]   <= bus.mem_rden;
        adr_p[1] <= bus.mem_address;
        for (int k = 2; k <= LAT; k++) begin
            vld[k]   <= vld[k-1];
            adr_p[k] <= adr_p[k-1];
        end
    end

    assign bus.mem_read_data = vld[LAT] ? mem_byte(adr_p[LAT]) : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [2:0] sels();
        return {bus.mem_prg_sel, bus.mem_chr_sel, bus.mem_ram_sel};
    endfunction

    task automatic wait_ack(input logic ppu, output int cyc);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!(ppu ? bus.ppu_ack : bus.cpu_ack) && cyc < 20);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad, k, ci, pi, cyc;
        logic exp_ppu;

        reset_n = 1'b0; cart_ready = 1'b0;
        bus.cpu_req = 0; bus.cpu_ram = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ppu_req = 0; bus.ppu_we = 0;  bus.ppu_addr = '0; bus.ppu_wdata = '0;
        repeat (3) @(negedge clock);

        // reset state
        chk("rst_strobes", {bus.mem_rden, bus.mem_wren, sels()}, 0);
        chk("rst_addr", bus.mem_address, 0);
        chk("rst_wdata", bus.mem_write_data, 0);
        chk("rst_acks", {bus.cpu_ack, bus.ppu_ack}, 0);
        chk("rst_rdata", {bus.cpu_rdata, bus.ppu_rdata}, 0);
        reset_n = 1'b1;

        // cart not ready: request must be ignored
        bus.cpu_req = 1; bus.cpu_addr = 21'h00123;
        bad = 0;
        repeat (20) begin
            @(negedge clock);
            if (bus.mem_rden || bus.mem_wren || sels() != 0 || bus.cpu_ack || bus.ppu_ack) bad++;
        end
        chk("not_ready_idle", bad, 0);
        cart_ready = 1'b1;

        // CPU PRG read 0x00123 -> 0xA5
        @(negedge clock);
        chk("rd_issue_strb", {bus.mem_rden, bus.mem_wren}, 2'b10);
        chk("rd_issue_sel", sels(), 3'b100);
        chk("rd_issue_addr", bus.mem_address, 21'h00123);
        @(negedge clock);
        chk("rd_c2_strb", {bus.mem_rden, sels()}, 0);
        chk("rd_c2_addr_hold", bus.mem_address, 21'h00123);
        @(negedge clock);
        chk("rd_c3_noack", bus.cpu_ack, 0);
        @(negedge clock);
        chk("rd_c4_ack", {bus.cpu_ack, bus.ppu_ack}, 2'b10);
        chk("rd_c4_rdata", bus.cpu_rdata, 8'hA5);
        chk("rd_c4_ppu_rdata", bus.ppu_rdata, 8'h00);
        bus.cpu_req = 0;
        @(negedge clock);
        chk("rd_ack_pulse", bus.cpu_ack, 0);
        chk("rd_rdata_hold", bus.cpu_rdata, 8'hA5);

        // PPU CHR write 0x01F00 <- 0x3C
        bus.ppu_req = 1; bus.ppu_we = 1; bus.ppu_addr = 21'h01F00; bus.ppu_wdata = 8'h3C;
        @(negedge clock);
        chk("wr_issue_strb", {bus.mem_rden, bus.mem_wren}, 2'b01);
        chk("wr_issue_sel", sels(), 3'b010);
        chk("wr_issue_addr", bus.mem_address, 21'h01F00);
        chk("wr_issue_data", bus.mem_write_data, 8'h3C);
        @(negedge clock);
        chk("wr_c2_ack", {bus.cpu_ack, bus.ppu_ack}, 2'b01);
        chk("wr_cpu_rdata_kept", bus.cpu_rdata, 8'hA5);
        bus.ppu_req = 0; bus.ppu_we = 0;
        @(negedge clock);
        chk("wr_c3_quiet", {bus.mem_wren, sels(), bus.ppu_ack}, 0);
        chk("wr_data_hold", bus.mem_write_data, 8'h3C);

        // CPU SRAM write 0x77
        bus.cpu_req = 1; bus.cpu_ram = 1; bus.cpu_we = 1; bus.cpu_addr = 21'h00042; bus.cpu_wdata = 8'h77;
        @(negedge clock);
        chk("ram_issue_sel", sels(), 3'b001);
        chk("ram_issue_wr", {bus.mem_wren, bus.mem_write_data}, {1'b1, 8'h77});
        @(negedge clock);
        chk("ram_ack", bus.cpu_ack, 1);
        bus.cpu_req = 0; bus.cpu_ram = 0; bus.cpu_we = 0;

        // contention: 4 reads each, requests held between grants
        bus.cpu_addr = 21'h00200; bus.ppu_addr = 21'h01000;
        bus.cpu_req = 1; bus.ppu_req = 1;
        k = 0; ci = 0; pi = 0; cyc = 0;
        while (k < 8 && cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (bus.cpu_ack || bus.ppu_ack) begin
`ifdef CART_ARB_ROUND_ROBIN_EN
                exp_ppu = (k % 2 == 0);
`else
                exp_ppu = (k < 4);
`endif
                chk($sformatf("arb_order%0d", k), bus.ppu_ack, exp_ppu);
                if (bus.ppu_ack) begin
                    chk($sformatf("arb_ppu_rdata%0d", pi), bus.ppu_rdata, mem_byte(bus.ppu_addr));
                    pi++; bus.ppu_addr = bus.ppu_addr + 1;
                    if (pi == 4) bus.ppu_req = 0;
                end else begin
                    chk($sformatf("arb_cpu_rdata%0d", ci), bus.cpu_rdata, mem_byte(bus.cpu_addr));
                    ci++; bus.cpu_addr = bus.cpu_addr + 1;
                    if (ci == 4) bus.cpu_req = 0;
                end
                k++;
            end
        end
        chk("arb_count", k, 8);
        bus.cpu_req = 0; bus.ppu_req = 0;
        @(negedge clock);

        // reset during WAIT of a PPU read, CPU also pending
        bus.ppu_addr = 21'h01311; bus.cpu_addr = 21'h00300;
        bus.ppu_req = 1; bus.cpu_req = 1;
        @(negedge clock);
        chk("rst_pre_issue_sel", sels(), 3'b010);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_strobes", {bus.mem_rden, sels(), bus.cpu_ack, bus.ppu_ack}, 0);
        chk("rst_mid_addr", bus.mem_address, 0);
        chk("rst_mid_rdata", {bus.cpu_rdata, bus.ppu_rdata}, 0);
        bad = 0;
        repeat (2) begin
            @(negedge clock);
            if (bus.cpu_ack || bus.ppu_ack) bad++;
        end
        chk("rst_no_ack", bad, 0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_reissue", {bus.mem_rden, sels(), bus.ppu_ack}, {1'b1, 3'b010, 1'b0});
        chk("rst_reissue_addr", bus.mem_address, 21'h01311);
        wait_ack(1'b1, cyc);
        chk("rst_ppu_ack_lat", cyc, 3);
        chk("rst_ppu_rdata", bus.ppu_rdata, 8'h4B);
        bus.ppu_req = 0;
        wait_ack(1'b0, cyc);
        chk("rst_cpu_ack_lat", cyc, 5);
        chk("rst_cpu_rdata", bus.cpu_rdata, 8'h5A);
        bus.cpu_req = 0;
        @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
